// File: rtl/imem_line_server_if.sv
// Cache-side line-fill handshake between the I-cache miss port and the line server.
// Ports: c_strobe_i/c_addr_i request (master drives), c_ready_o/c_data_o response (slave drives).
interface imem_line_server_if #(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 256
);
  logic              c_strobe_i;
  logic [XLEN-1:0]   c_addr_i;
  logic              c_ready_o;
  logic [CLSIZE-1:0] c_data_o;

  modport master (
    output c_strobe_i, c_addr_i,
    input  c_ready_o, c_data_o
  );

  modport slave (
    input  c_strobe_i, c_addr_i,
    output c_ready_o, c_data_o
  );
endinterface

// File: rtl/imem_line_server.sv
// Serves 8-word I-cache line fills from a word-wide synchronous memory.
// Ports: clk_i, rst_ni, c (cache slave), mem_en_o/mem_addr_o/mem_rdata_i, busy_o, lines_served_o.
module imem_line_server #(
  parameter int XLEN    = 32,
  parameter int CLSIZE  = 256,
  parameter int AW      = 14,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  imem_line_server_if.slave    c,
  output logic                 mem_en_o,
  output logic [AW-1:0]        mem_addr_o,
  input  logic [31:0]          mem_rdata_i,
  output logic                 busy_o,
  output logic [31:0]          lines_served_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP,
    HOLD
  } state_t;

  state_t       state;
  logic [AW-4:0] base;
  logic [2:0]   issue_cnt;
  logic [2:0]   cap_cnt;
  logic [MEM_LAT-1:0] pv;
  logic [2:0]   pidx [MEM_LAT];

  logic       cap_v;
  logic [2:0] cap_idx;
  assign cap_v   = pv[MEM_LAT-1];
  assign cap_idx = pidx[MEM_LAT-1];

  logic unused_addr;
  assign unused_addr = ^{c.c_addr_i[XLEN-1:AW+2], c.c_addr_i[4:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      base           <= '0;
      issue_cnt      <= '0;
      cap_cnt        <= '0;
      pv             <= '0;
      for (int i = 0; i < MEM_LAT; i++) pidx[i] <= '0;
      c.c_ready_o    <= 1'b0;
      c.c_data_o     <= '0;
      mem_en_o       <= 1'b0;
      mem_addr_o     <= '0;
      busy_o         <= 1'b0;
      lines_served_o <= '0;
    end else begin
      // word index rides alongside each read until its data returns
      pv[0]   <= mem_en_o;
      pidx[0] <= mem_addr_o[2:0];
      for (int i = 1; i < MEM_LAT; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end

      if (cap_v) begin
        c.c_data_o[CLSIZE-1-32*int'(cap_idx) -: 32] <= mem_rdata_i;
        cap_cnt <= cap_cnt + 3'd1;
      end

      unique case (state)
        IDLE: begin
          if (c.c_strobe_i) begin
            base       <= c.c_addr_i[AW+1:5];
            mem_addr_o <= {c.c_addr_i[AW+1:5], 3'd0};
            mem_en_o   <= 1'b1;
            issue_cnt  <= 3'd1;
            cap_cnt    <= '0;
            busy_o     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_addr_o[2:0] == 3'd7) begin
            mem_en_o <= 1'b0;
            state    <= DRAIN;
          end else begin
            mem_addr_o <= {base, issue_cnt};
            issue_cnt  <= issue_cnt + 3'd1;
          end
        end
        DRAIN: begin
          if (cap_v && cap_cnt == 3'd7) begin
            c.c_ready_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          c.c_ready_o    <= 1'b0;
          lines_served_o <= lines_served_o + 32'd1;
          state          <= HOLD;
        end
        HOLD: begin
          // a strobe still held from the served request must not refill
          if (!c.c_strobe_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_line_server.sv
// Bench for imem_line_server: two instances (MEM_LAT 1 and 3) with ideal memories,
// a timeline model per instance checked every cycle, plus directed literal checks.
module tb_imem_line_server;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [1:0]   strobe;
  logic [31:0]  addr [2];
  logic [1:0]   ready;
  logic [1:0]   en;
  logic [1:0]   busy;
  logic [255:0] data [2];
  logic [13:0]  maddr [2];
  logic [31:0]  served [2];
  logic [1:0]   preload;

  task automatic chk(string n, int ln, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s lane%0d: got %h want %h", n, ln, a, e);
    end
  endtask

  function automatic logic [255:0] exp_line(logic [10:0] b);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      v[255-32*i -: 32] = 32'hA000_0000 + 32'(b) * 32'd8 + 32'(i);
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = (g == 0) ? 1 : 3;

    imem_line_server_if #(.XLEN(32), .CLSIZE(256)) bus ();
    logic [31:0] rdata;

    assign bus.c_strobe_i = strobe[g];
    assign bus.c_addr_i   = addr[g];
    assign ready[g]       = bus.c_ready_o;
    assign data[g]        = bus.c_data_o;

    imem_line_server #(
      .XLEN(32), .CLSIZE(256), .AW(14), .MEM_LAT(L)
    ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .c              (bus),
      .mem_en_o       (en[g]),
      .mem_addr_o     (maddr[g]),
      .mem_rdata_i    (rdata),
      .busy_o         (busy[g]),
      .lines_served_o (served[g])
    );

    // ideal memory: word n holds A000_0000+n, returned exactly L cycles later
    logic        mv [L];
    logic [13:0] ma [L];
    always @(posedge clk) begin
      mv[0] <= en[g];
      ma[0] <= maddr[g];
      for (int i = 1; i < L; i++) begin
        mv[i] <= mv[i-1];
        ma[i] <= ma[i-1];
      end
    end
    assign rdata = mv[L-1] ? 32'hA000_0000 + {18'd0, ma[L-1]}
                           : 32'hDEAD_BEEF;

    // timeline model: r = cycles since the sampling cycle T
    int          r;
    bit          act;
    logic [31:0] ms;
    logic [10:0] mb;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act = 1'b0;
        r   = 0;
        ms  = '0;
      end else begin
        if (preload[g]) ms = 32'hFFFF_FFFF;
        if (!act) begin
          if (strobe[g]) begin
            act = 1'b1;
            r   = 1;
            mb  = addr[g][15:5];
          end
        end else begin
          if (r == 9 + L) ms = ms + 32'd1;
          if (r >= 10 + L && !strobe[g]) act = 1'b0;
          else r = r + 1;
        end
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        chk("rst_ready", g, ready[g], 0);
        chk("rst_en", g, en[g], 0);
        chk("rst_addr", g, maddr[g], 0);
        chk("rst_busy", g, busy[g], 0);
        chk("rst_served", g, served[g], 0);
        chk("rst_data", g, data[g], 0);
      end else begin
        chk("busy", g, busy[g], act);
        chk("mem_en", g, en[g], act && r >= 1 && r <= 8);
        if (act && r >= 1 && r <= 8)
          chk("mem_addr", g, maddr[g], {mb, 3'(r - 1)});
        chk("ready", g, ready[g], act && r == 9 + L);
        if (act && r == 9 + L)
          chk("line", g, data[g], exp_line(mb));
        if (!preload[g])
          chk("served", g, served[g], ms);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // call at posedge+2; returns at the negedge of the ready cycle
  task automatic run_fill(input int ln, input logic [31:0] a,
                          output int lat, output int ens);
    strobe[ln] = 1'b1;
    addr[ln]   = a;
    lat = -1;
    ens = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (en[ln]) ens++;
      if (ready[ln]) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ens;
    strobe  = '0;
    preload = '0;
    addr[0] = '0;
    addr[1] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_busy", 0, busy[0], 0);
    chk("init_served", 1, served[1], 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1);

    // single fill, L=1
    run_fill(0, 32'h0000_0040, lat, ens);
    chk("s1_lat", 0, lat, 10);
    chk("s1_ens", 0, ens, 8);
    chk("s1_w0", 0, data[0][255:224], 32'hA000_0010);
    chk("s1_w7", 0, data[0][31:0], 32'hA000_0017);

    // strobe held two cycles past ready
    step(2);
    chk("s2_served", 0, served[0], 1);
    chk("s2_no_en", 0, en[0], 0);
    step(1);
    strobe[0] = 1'b0;
    step(3);

    // low address bits ignored
    run_fill(0, 32'h0000_005C, lat, ens);
    chk("s3_lat", 0, lat, 10);
    chk("s3_w0", 0, data[0][255:224], 32'hA000_0010);
    chk("s3_w7", 0, data[0][31:0], 32'hA000_0017);
    step(1);
    strobe[0] = 1'b0;
    step(2);
    chk("s3_served", 0, served[0], 2);

    // L=3, two requests
    run_fill(1, 32'h0000_0020, lat, ens);
    chk("s4a_lat", 1, lat, 12);
    chk("s4a_w0", 1, data[1][255:224], 32'hA000_0008);
    chk("s4a_w7", 1, data[1][31:0], 32'hA000_000F);
    step(1);
    strobe[1] = 1'b0;
    step(2);
    run_fill(1, 32'h0000_03E0, lat, ens);
    chk("s4b_lat", 1, lat, 12);
    chk("s4b_w0", 1, data[1][255:224], 32'hA000_00F8);
    chk("s4b_w7", 1, data[1][31:0], 32'hA000_00FF);
    step(1);
    strobe[1] = 1'b0;
    step(2);
    chk("s4_served", 1, served[1], 2);

    // reset during the 5th issue cycle
    strobe[0] = 1'b1;
    addr[0]   = 32'h0000_0080;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_en", 0, en[0], 0);
    chk("s5_addr", 0, maddr[0], 0);
    chk("s5_busy", 0, busy[0], 0);
    chk("s5_served", 0, served[0], 0);
    chk("s5_data", 0, data[0], 0);
    step(2);
    rst_n = 1'b1;
    run_fill(0, 32'h0000_0080, lat, ens);
    chk("s5_lat", 0, lat, 10);
    chk("s5_ens", 0, ens, 8);
    chk("s5_w0", 0, data[0][255:224], 32'hA000_0020);
    chk("s5_w7", 0, data[0][31:0], 32'hA000_0027);
    step(1);
    strobe[0] = 1'b0;
    step(2);
    chk("s5_served_after", 0, served[0], 1);
    chk("s5_lane1_cleared", 1, served[1], 0);

    // counter wrap
    force lane[0].dut.lines_served_o = 32'hFFFF_FFFF;
    preload[0] = 1'b1;
    step(1);
    release lane[0].dut.lines_served_o;
    preload[0] = 1'b0;
    @(negedge clk);
    chk("s6_pre", 0, served[0], 32'hFFFF_FFFF);
    step(1);
    run_fill(0, 32'h0000_0040, lat, ens);
    chk("s6_lat", 0, lat, 10);
    step(1);
    strobe[0] = 1'b0;
    step(2);
    chk("s6_wrap", 0, served[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
